data_mem_port: RTL and testbench
================================

// Module: data_mem_port
// PURPOSE
// - Byte-addressable data memory with a request/ready handshake. Sits directly downstream of the riscv core's
//   load/store bus (wr, rd, addr, wr_data) and returns rd_data to the core's writeback path.
// - Handles RV32I sub-word loads/stores selected by funct3 and models a configurable access latency.
// - Core stalls while busy is high; one access is in flight at a time.
// PARAMETERS
// - DATA_W   32  data word width in bits; fixed at 32 for RV32I.
// - ADDR_W   9   byte-address width; memory depth = 2**ADDR_W bytes.
// - LATENCY  2   wait cycles before the access is performed (0..15).
// PORTS
// - clk       in   1       clock; all logic on the rising edge
// - reset     in   1       synchronous, active-low reset (reset==0 resets on the clk edge)
// - rd        in   1       load request
// - wr        in   1       store request
// - addr      in   ADDR_W  byte address
// - funct3    in   3       access size/sign, RV32I encoding
// - wr_data   in   DATA_W  store data, LSB-aligned
// - rd_data   out  DATA_W  load result, sign- or zero-extended
// - ready     out  1       one-cycle pulse: access complete
// - busy      out  1       request accepted and not yet completed
// - err       out  1       one-cycle pulse with ready: access rejected
// BEHAVIOUR
// - Reset: state=IDLE; cnt=0; rd_data=0; ready=0; busy=0; err=0. Memory array is not cleared and keeps its contents.
// - FSM IDLE: if rd|wr is sampled, latch addr/funct3/wr_data/op, set busy=1, cnt=LATENCY, go to WAIT.
// - FSM WAIT: while cnt!=0, cnt--. At cnt==0, perform the access and go to DONE.
// - FSM DONE: ready=1 for one cycle and busy=0, then go to IDLE.
// - Latency: request sampled in cycle N -> ready in cycle N+LATENCY+2.
//   A new request is accepted in the cycle after ready.
// - rd/wr/addr changes while busy=1 are ignored. All operands are used from the latched copy.
// - rd and wr both high: reject (err=1 with ready), no memory change.
// - Byte order is little-endian: byte addr holds bits [7:0].
// - funct3 encoding:
//   - Loads: 000 LB (sign-extend), 001 LH (sign-extend), 010 LW, 100 LBU (zero-extend), 101 LHU (zero-extend).
//   - Stores: 000 SB, 001 SH, 010 SW. Only the addressed bytes are written.
// - Any other funct3: reject (err=1), no write, rd_data unchanged.
// - rd_data updates only when a load completes without error, and holds until the next successful load.
// - Stores leave rd_data unchanged.
// - Reset mid-operation (WAIT/DONE): abort. No write is committed unless it was already performed. Return to IDLE.
// - Misalignment: a halfword with addr[0]!=0, or a word with addr[1:0]!=0. Handling is set by CONFIGURATION.
// - Aligned accesses never wrap past 2**ADDR_W-1.
// CONFIGURATION
// - Macro: MISALIGN_TRAP_EN.
// - Defined: a misaligned access is rejected with err=1 at ready. No write is performed and rd_data is unchanged.
// - Undefined: the low address bits are forced to zero (halfword: addr[0]=0; word: addr[1:0]=0).
//   The access then proceeds normally with err=0.
// TESTING
// - Reset, then SW addr=0x010 data=0xDEADBEEF, then LW 0x010 -> rd_data=0xDEADBEEF, err=0.
//   ready arrives exactly LATENCY+2 cycles after each request.
// - After the above: SB addr=0x011 data=0x000000AA.
//   Then LW 0x010 -> 0xDEADAAEF; LB 0x011 -> 0xFFFFFFAA; LBU 0x011 -> 0x000000AA.
// - SH addr=0x020 data=0x00008001.
//   Then LH 0x020 -> 0xFFFF8001; LHU 0x020 -> 0x00008001.
// - With word 0x030 = 0x11223344: LW addr=0x032.
//   MISALIGN_TRAP_EN defined -> err=1 and rd_data unchanged. Undefined -> rd_data=0x11223344, err=0.
// - Illegal requests: rd=wr=1, and funct3=011 store -> err=1 with ready, memory unchanged.
//   Request toggled while busy=1 -> ignored, no extra ready.
// - Abort: SW 0x040=0x12345678 with reset low during WAIT (LATENCY=2), then LW 0x040 -> prior value unchanged.
//   All outputs read 0 in the cycle after reset.

Source files
------------

// File: rtl/data_mem_port.sv
// Byte-addressable RV32I data memory with request/ready handshake and fixed access latency.
// Optional macro MISALIGN_TRAP_EN: reject misaligned half/word accesses instead of aligning them down.
module data_mem_port #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              busy,
  output logic              err
);
  localparam int          DEPTH = 2**ADDR_W;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_rd, r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_funct3;
  logic [DATA_W-1:0]   r_wdata;
  logic [7:0]          r_mem [DEPTH];

  logic                w_misalign, w_f3_ok, w_reject, w_fire, w_do_wr;
  logic [ADDR_W-1:0]   w_a0, w_a1, w_a2, w_a3;
  logic [7:0]          w_b0, w_b1, w_b2, w_b3;
  logic [DATA_W-1:0]   w_ld;

  assign w_misalign = (r_funct3[1:0] == 2'b01 && r_addr[0]) ||
                      (r_funct3[1:0] == 2'b10 && r_addr[1:0] != 2'b00);

  always_comb begin
    w_f3_ok = 1'b0;
    if (r_rd)
      w_f3_ok = (r_funct3 == 3'b000) || (r_funct3 == 3'b001) || (r_funct3 == 3'b010) ||
                (r_funct3 == 3'b100) || (r_funct3 == 3'b101);
    else
      w_f3_ok = (r_funct3 == 3'b000) || (r_funct3 == 3'b001) || (r_funct3 == 3'b010);
  end

`ifdef MISALIGN_TRAP_EN
  assign w_reject = (r_rd & r_wr) | ~w_f3_ok | w_misalign;
  assign w_a0     = r_addr;
`else
  assign w_reject = (r_rd & r_wr) | ~w_f3_ok;
  // Misaligned accesses are silently aligned down to their natural boundary.
  always_comb begin
    w_a0 = r_addr;
    if (r_funct3[1:0] == 2'b01) w_a0[0]   = 1'b0;
    if (r_funct3[1:0] == 2'b10) w_a0[1:0] = 2'b00;
  end
`endif

  // Aligned half/word accesses keep their upper bytes inside the same word, so OR suffices.
  assign w_a1 = w_a0 | ADDR_W'(1);
  assign w_a2 = w_a0 | ADDR_W'(2);
  assign w_a3 = w_a0 | ADDR_W'(3);
  assign w_b0 = r_mem[w_a0];
  assign w_b1 = r_mem[w_a1];
  assign w_b2 = r_mem[w_a2];
  assign w_b3 = r_mem[w_a3];

  always_comb begin
    w_ld = rd_data;
    case (r_funct3)
      3'b000:  w_ld = {{(DATA_W-8){w_b0[7]}}, w_b0};
      3'b001:  w_ld = {{(DATA_W-16){w_b1[7]}}, w_b1, w_b0};
      3'b010:  w_ld = {w_b3, w_b2, w_b1, w_b0};
      3'b100:  w_ld = {{(DATA_W-8){1'b0}}, w_b0};
      3'b101:  w_ld = {{(DATA_W-16){1'b0}}, w_b1, w_b0};
      default: w_ld = rd_data;
    endcase
  end

  assign w_fire  = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_do_wr = w_fire & r_wr & ~w_reject;

  // Memory has no reset; a reset on the firing edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (reset && w_do_wr) begin
      r_mem[w_a0] <= r_wdata[7:0];
      if (r_funct3[1:0] != 2'b00) r_mem[w_a1] <= r_wdata[15:8];
      if (r_funct3[1:0] == 2'b10) begin
        r_mem[w_a2] <= r_wdata[23:16];
        r_mem[w_a3] <= r_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      rd_data  <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_funct3 <= 3'b000;
      r_wdata  <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rd | wr) begin
            r_rd     <= rd;
            r_wr     <= wr;
            r_addr   <= addr;
            r_funct3 <= funct3;
            r_wdata  <= wr_data;
            busy     <= 1'b1;
            r_cnt    <= LAT;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            ready   <= 1'b1;
            err     <= w_reject;
            busy    <= 1'b0;
            if (r_rd && !w_reject) rd_data <= w_ld;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_port.sv
// Scoreboard bench for data_mem_port: directed load/store vectors, latency, reject and abort cases.
module tb_data_mem_port;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [8:0]  addr = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        ready, busy, err;

  data_mem_port #(.DATA_W(32), .ADDR_W(9), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .funct3(funct3),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        e_err;
    logic [31:0] e_rd;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin
        if (q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_ready: got ready=1, expected no response");
        end else begin
          e = q.pop_front();
          check($sformatf("txn%0d_err", n_txn), {31'd0, err}, {31'd0, e.e_err});
          check($sformatf("txn%0d_rd_data", n_txn), rd_data, e.e_rd);
          n_txn++;
        end
      end
    end
  end

  // Called just after a posedge; request is sampled on the next edge.
  task automatic req(input logic r, input logic w, input logic [8:0] a, input logic [2:0] f,
                     input logic [31:0] d, input logic e_err, input logic [31:0] e_rd,
                     input logic toggle);
    int cyc;
    q.push_back('{e_err: e_err, e_rd: e_rd});
    rd = r; wr = w; addr = a; funct3 = f; wr_data = d;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    cyc = 1;
    while (ready !== 1'b1 && cyc < 20) begin
      if (toggle) begin
        rd = cyc[0]; wr = ~cyc[0]; addr = 9'h010; funct3 = 3'b000; wr_data = 32'hFFFF_FFFF;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd = 1'b0; wr = 1'b0;
    check("latency", cyc, LAT + 2);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [31:0] mis_rd, after_mis;
  logic        mis_err;

  initial begin
    reset = 1'b0;
    idle(3);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    reset = 1'b1;
    idle(1);

    req(1'b0, 1'b1, 9'h010, 3'b010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0);
    req(1'b1, 1'b0, 9'h010, 3'b010, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0);
    req(1'b0, 1'b1, 9'h011, 3'b000, 32'h0000_00AA, 1'b0, 32'hDEAD_BEEF, 1'b0);
    req(1'b1, 1'b0, 9'h010, 3'b010, 32'h0,         1'b0, 32'hDEAD_AAEF, 1'b0);
    req(1'b1, 1'b0, 9'h011, 3'b000, 32'h0,         1'b0, 32'hFFFF_FFAA, 1'b0);
    req(1'b1, 1'b0, 9'h011, 3'b100, 32'h0,         1'b0, 32'h0000_00AA, 1'b0);
    req(1'b0, 1'b1, 9'h020, 3'b001, 32'h0000_8001, 1'b0, 32'h0000_00AA, 1'b0);
    req(1'b1, 1'b0, 9'h020, 3'b001, 32'h0,         1'b0, 32'hFFFF_8001, 1'b0);
    req(1'b1, 1'b0, 9'h020, 3'b101, 32'h0,         1'b0, 32'h0000_8001, 1'b0);
    req(1'b0, 1'b1, 9'h030, 3'b010, 32'h1122_3344, 1'b0, 32'h0000_8001, 1'b0);

`ifdef MISALIGN_TRAP_EN
    mis_err = 1'b1; mis_rd = 32'h0000_8001; after_mis = 32'h0000_8001;
`else
    mis_err = 1'b0; mis_rd = 32'h1122_3344; after_mis = 32'hFFFF_8001;
`endif
    req(1'b1, 1'b0, 9'h032, 3'b010, 32'h0, mis_err, mis_rd, 1'b0);
    req(1'b1, 1'b0, 9'h021, 3'b001, 32'h0, mis_err, after_mis, 1'b0);

    // Rejected requests: both strobes, and an illegal store size.
    req(1'b1, 1'b1, 9'h010, 3'b010, 32'h0,         1'b1, after_mis, 1'b0);
    req(1'b0, 1'b1, 9'h010, 3'b011, 32'h5555_5555, 1'b1, after_mis, 1'b0);
    req(1'b1, 1'b0, 9'h010, 3'b010, 32'h0,         1'b0, 32'hDEAD_AAEF, 1'b0);

    // Inputs thrash while busy; only the latched load completes.
    req(1'b1, 1'b0, 9'h030, 3'b010, 32'h0, 1'b0, 32'h1122_3344, 1'b1);
    idle(6);
    req(1'b1, 1'b0, 9'h010, 3'b010, 32'h0, 1'b0, 32'hDEAD_AAEF, 1'b0);

    // Abort a store in WAIT.
    req(1'b0, 1'b1, 9'h040, 3'b010, 32'hCAFE_F00D, 1'b0, 32'hDEAD_AAEF, 1'b0);
    wr = 1'b1; addr = 9'h040; funct3 = 3'b010; wr_data = 32'h1234_5678;
    @(posedge clk); #1;
    wr = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    check("abort_rd_data", rd_data, 32'd0);
    reset = 1'b1;
    idle(5);
    req(1'b1, 1'b0, 9'h040, 3'b010, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0);
    idle(4);

    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL missing_responses: got %0d outstanding, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
